// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: per-stage hold and flush generation for the in-order pipeline,
// with a timed flush window, per-requester stall-cycle counters and a stall-hang watchdog.
module pipe_stall_ctrl #(
    parameter int STAGES = 6,
    parameter int NREQ = 4,
    parameter logic [NREQ*STAGES-1:0] MASKS = {6'b011111, 6'b000111, 6'b000011, 6'b000010},
    parameter logic [STAGES-1:0] FLUSH_MASK = 6'b000011,
    parameter int FLUSH_LEN = 2,
    parameter int CNT_W = 16,
    parameter int TIMEOUT = 1024,
    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NREQ-1:0]   req,
    input  logic              flush_req,
    input  logic              clr_cnt,
    input  logic [SEL_W-1:0]  cnt_sel,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic [CNT_W-1:0]  cnt_val,
    output logic              hang
);

    localparam int FCNT_W = $clog2(FLUSH_LEN + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_LEN - 1);
    localparam logic [WCNT_W-1:0] WD_MAX = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WD_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STAGES-1:0] raw;
    logic [FCNT_W-1:0] fcnt;
    logic [WCNT_W-1:0] wcnt;
    logic              flush_act;
    logic              stalled;
    logic [CNT_W-1:0]  cnt [NREQ];

    // Masks nest, so a plain OR already yields mem > id > if > jump priority.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) raw = raw | MASKS[i*STAGES +: STAGES];
        end
    end

    assign flush_act = flush_req | (fcnt != '0);

    always_comb begin
        stall = '0;
        flush = '0;
        if (rst) begin
            stall = '0;
            flush = '0;
        end else if (!rdy) begin
            stall = '1;
        end else begin
            flush = flush_act ? FLUSH_MASK : '0;
            stall = raw & ~flush;
        end
    end

    // The window only advances on rdy-high cycles, so a freeze suspends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
        end else if (rdy) begin
            if (flush_req) fcnt <= FLUSH_RELOAD;
            else if (fcnt != '0) fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst || clr_cnt) begin
                cnt[i] <= '0;
            end else if (rdy && req[i] && cnt[i] != CNT_MAX) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cnt_sel == SEL_W'(i)) cnt_val = cnt[i];
        end
    end

    assign stalled = rdy && (stall != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
            hang <= 1'b0;
        end else if (rdy) begin
            if (stalled) begin
                if (wcnt != WD_MAX) wcnt <= wcnt + 1'b1;
                if (wcnt == WD_LAST) hang <= 1'b1;
            end else begin
                wcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (CNT_W=4, TIMEOUT=8); expectations are queued per cycle
// and a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

    localparam int W = 29;

    logic       clk;
    logic       rst;
    logic       rdy;
    logic [3:0] req;
    logic       flush_req;
    logic       clr_cnt;
    logic [1:0] cnt_sel;
    logic [5:0] stall;
    logic [5:0] flush;
    logic [3:0] cnt_val;
    logic       hang;

    logic [W-1:0] exp_q[$];
    int assertions = 0;
    int failures = 0;
    int vec_id = 0;

    pipe_stall_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .flush_req(flush_req),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .stall(stall), .flush(flush),
        .cnt_val(cnt_val), .hang(hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry: {id[7:0], check mask[3:0] (stall,flush,cnt,hang), stall, flush, cnt, hang}
    task automatic cyc(input logic r, input logic rd, input logic [3:0] rq, input logic fr,
                       input logic cl, input logic [1:0] sel, input logic [3:0] m,
                       input logic [5:0] es, input logic [5:0] ef, input logic [3:0] ec,
                       input logic eh);
        @(posedge clk);
        #1;
        rst = r;
        rdy = rd;
        req = rq;
        flush_req = fr;
        clr_cnt = cl;
        cnt_sel = sel;
        exp_q.push_back({8'(vec_id), m, es, ef, ec, eh});
        vec_id++;
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e[20]) begin
                assertions++;
                if (stall !== e[16:11]) begin
                    failures++;
                    $display("FAIL vec%0d stall: got %b want %b", e[28:21], stall, e[16:11]);
                end
            end
            if (e[19]) begin
                assertions++;
                if (flush !== e[10:5]) begin
                    failures++;
                    $display("FAIL vec%0d flush: got %b want %b", e[28:21], flush, e[10:5]);
                end
            end
            if (e[18]) begin
                assertions++;
                if (cnt_val !== e[4:1]) begin
                    failures++;
                    $display("FAIL vec%0d cnt_val: got %0d want %0d", e[28:21], cnt_val, e[4:1]);
                end
            end
            if (e[17]) begin
                assertions++;
                if (hang !== e[0]) begin
                    failures++;
                    $display("FAIL vec%0d hang: got %b want %b", e[28:21], hang, e[0]);
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; rdy = 1'b1; req = 4'b0; flush_req = 1'b0; clr_cnt = 1'b0; cnt_sel = 2'd0;

        // reset: outputs forced low even with requests and flush pending
        cyc(1, 1, 4'b1111, 1, 0, 2'd0, 4'b1100, 6'b000000, 6'b000000, 4'd0, 0);
        cyc(1, 1, 4'b1111, 1, 0, 2'd0, 4'hF, 6'b000000, 6'b000000, 4'd0, 0);

        // raw stall patterns (cnt0 counts jump requests)
        cyc(0, 1, 4'b1001, 0, 0, 2'd0, 4'hF, 6'b011111, 6'b000000, 4'd0, 0);
        cyc(0, 1, 4'b0011, 0, 0, 2'd0, 4'hF, 6'b000011, 6'b000000, 4'd1, 0);
        cyc(0, 1, 4'b0001, 0, 0, 2'd0, 4'hF, 6'b000010, 6'b000000, 4'd2, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd0, 4'hF, 6'b000000, 6'b000000, 4'd3, 0);

        // flush window with id stall: flush beats hold on stages 0..1
        cyc(0, 1, 4'b0100, 1, 0, 2'd2, 4'hF, 6'b000100, 6'b000011, 4'd0, 0);
        cyc(0, 1, 4'b0100, 0, 0, 2'd2, 4'hF, 6'b000100, 6'b000011, 4'd1, 0);
        cyc(0, 1, 4'b0100, 0, 0, 2'd2, 4'hF, 6'b000111, 6'b000000, 4'd2, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000000, 4'd3, 0);

        // freeze suspends the window; second flush_req restarts it
        cyc(0, 1, 4'b0000, 1, 0, 2'd2, 4'hF, 6'b000000, 6'b000011, 4'd3, 0);
        cyc(0, 0, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b111111, 6'b000000, 4'd3, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000011, 4'd3, 0);
        cyc(0, 1, 4'b0000, 1, 0, 2'd2, 4'hF, 6'b000000, 6'b000011, 4'd3, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000011, 4'd3, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000000, 4'd3, 0);
        // flush_req and req during freeze are ignored / not counted
        cyc(0, 0, 4'b0100, 1, 0, 2'd2, 4'hF, 6'b111111, 6'b000000, 4'd3, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000000, 4'd3, 0);

        // saturation: if request held 20 cycles under continuous flush (stall stays 0)
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 4'b0010, 1, 0, 2'd1, 4'hF, 6'b000000, 6'b000011,
                (k + 1 > 15) ? 4'd15 : 4'(k + 1), 0);
        end
        // clear beats the id increment in the same cycle
        cyc(0, 1, 4'b0100, 0, 1, 2'd1, 4'hF, 6'b000100, 6'b000011, 4'd15, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd1, 4'hF, 6'b000000, 6'b000000, 4'd0, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd2, 4'hF, 6'b000000, 6'b000000, 4'd0, 0);

        // watchdog: 4 stalls, one stall-free cycle, then 8 stalls raise hang
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 4'b1000, 0, 0, 2'd3, 4'hF, 6'b011111, 6'b000000, 4'(k), 0);
        end
        cyc(0, 1, 4'b0000, 0, 0, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd4, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 4'b1000, 0, 0, 2'd3, 4'hF, 6'b011111, 6'b000000, 4'(4 + k), 0);
        end
        cyc(0, 1, 4'b0000, 0, 0, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd12, 1);
        cyc(0, 1, 4'b0000, 0, 1, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd12, 1);
        cyc(0, 1, 4'b0000, 0, 0, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd0, 1);

        // reset during an open flush window with a nonzero counter and hang set
        cyc(0, 1, 4'b1000, 1, 0, 2'd3, 4'hF, 6'b011100, 6'b000011, 4'd0, 1);
        cyc(1, 1, 4'b1000, 0, 0, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd1, 1);
        cyc(0, 1, 4'b0000, 0, 0, 2'd3, 4'hF, 6'b000000, 6'b000000, 4'd0, 0);
        cyc(0, 1, 4'b0000, 0, 0, 2'd0, 4'hF, 6'b000000, 6'b000000, 4'd0, 0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            assertions++;
            failures++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
